// File: rtl/cube_pkg.sv
// Shared types and constants for the 3x3x3 LED cube scan path.
// Frame bit index is plane*9 + layer*3 + row.
package cube_pkg;

    localparam int NUM_PLANES     = 3;
    localparam int ROWS_PER_PLANE = 9;
    localparam int FRAME_W        = 27;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_e;

    function automatic logic [ROWS_PER_PLANE-1:0] plane_slice(
        input logic [FRAME_W-1:0] f,
        input logic [1:0]         p
    );
        logic [ROWS_PER_PLANE-1:0] s;
        case (p)
            2'd1:    s = f[17:9];
            2'd2:    s = f[26:18];
            default: s = f[8:0];
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cube_frame_dbuf.sv
// Pending/active frame double buffer with a valid/ready load port.
// A swap request only moves data when the pending slot holds a frame.
module cube_frame_dbuf
    import cube_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               swap_req_i,
    output logic [FRAME_W-1:0] active_o
);

    logic [FRAME_W-1:0] pending_q, pending_d;
    logic [FRAME_W-1:0] active_q, active_d;
    logic               full_q, full_d;
    logic               accept;

    assign accept   = valid_i & ~full_q;
    assign ready_o  = ~full_q;
    assign active_o = active_q;

    // Accept needs an empty slot and swap needs a full one, so they never collide.
    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        full_d    = full_q;
        if (swap_req_i && full_q) begin
            active_d = pending_q;
            full_d   = 1'b0;
        end
        if (accept) begin
            pending_d = frame_i;
            full_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            active_q  <= '0;
            full_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            full_q    <= full_d;
        end
    end

endmodule

// File: rtl/cube_scan_scheduler.sv
// Plane-by-plane scan controller for the 3x3x3 LED cube with
// blanking between planes; outputs decode registers only.
module cube_scan_scheduler
    import cube_pkg::*;
#(
    parameter int DWELL_TICKS = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic                      enable,
    input  logic [FRAME_W-1:0]        frame_in,
    input  logic                      frame_in_valid,
    output logic                      frame_in_ready,
    output logic [NUM_PLANES-1:0]     vert,
    output logic [ROWS_PER_PLANE-1:0] row,
    output logic [1:0]                cur_plane,
    output logic                      frame_done,
    output logic                      busy
);

    localparam int MAX_T = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
    localparam int CW    = $clog2((MAX_T > 2) ? MAX_T : 2);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST =
        (BLANK_TICKS > 0) ? CW'(BLANK_TICKS - 1) : '0;
    localparam state_e     NEXT_PHASE = (BLANK_TICKS > 0) ? S_BLANK : S_DRIVE;
    localparam logic [1:0] LAST_PLANE = 2'(NUM_PLANES - 1);

    state_e               state_q, state_d;
    logic [1:0]           plane_q, plane_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 swap_req;
    logic [FRAME_W-1:0]   active;

    cube_frame_dbuf u_dbuf (
        .clk        (clk),
        .rst        (rst),
        .frame_i    (frame_in),
        .valid_i    (frame_in_valid),
        .ready_o    (frame_in_ready),
        .swap_req_i (swap_req),
        .active_o   (active)
    );

    always_comb begin
        state_d  = state_q;
        plane_d  = plane_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        swap_req = (state_q == S_IDLE);
        if (!enable) begin
            state_d = S_IDLE;
            plane_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = NEXT_PHASE;
                    plane_d = '0;
                    cnt_d   = '0;
                end
                S_BLANK: begin
                    if (tick) begin
                        if (cnt_q == BLANK_LAST) begin
                            state_d = S_DRIVE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_DRIVE: begin
                    if (tick) begin
                        if (cnt_q != DWELL_LAST) begin
                            cnt_d = cnt_q + 1'b1;
                        end else begin
                            cnt_d   = '0;
                            state_d = NEXT_PHASE;
                            // Frame swap only at scan end keeps frames untorn.
                            if (plane_q == LAST_PLANE) begin
                                plane_d  = '0;
                                done_d   = 1'b1;
                                swap_req = 1'b1;
                            end else begin
                                plane_d = plane_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            plane_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            plane_q <= plane_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign vert = (state_q == S_DRIVE) ? (3'b001 << plane_q) : '0;
    assign row  = (state_q == S_DRIVE) ? plane_slice(active, plane_q) : '0;
    assign cur_plane  = plane_q;
    assign frame_done = done_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_cube_scan_scheduler.sv
// Directed scoreboard bench: two scheduler instances, one per
// timing configuration, checked every clock cycle.
module tb_cube_scan_scheduler;

    typedef struct packed {
        logic [2:0] vert;
        logic [8:0] row;
        logic [1:0] plane;
        logic       done;
        logic       busy;
        logic       ready;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, tick, enable, valid;
    logic [26:0] frame;
    logic        ready;
    logic [2:0]  vert;
    logic [8:0]  row;
    logic [1:0]  cur_plane;
    logic        done, busy;

    logic        rst2, tick2, en2, valid2;
    logic [26:0] frame2;
    logic        ready2;
    logic [2:0]  vert2;
    logic [8:0]  row2;
    logic [1:0]  plane2;
    logic        done2, busy2;

    int   tests = 0;
    int   fails = 0;
    bit   sel = 1'b0;
    exp_t sb[$];

    localparam logic [26:0] F2 = {9'h100, 9'h0AA, 9'h155};

    always #5 clk = ~clk;

    cube_scan_scheduler #(.DWELL_TICKS(2), .BLANK_TICKS(1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .enable(enable),
        .frame_in(frame), .frame_in_valid(valid),
        .frame_in_ready(ready), .vert(vert), .row(row),
        .cur_plane(cur_plane), .frame_done(done), .busy(busy)
    );

    cube_scan_scheduler #(.DWELL_TICKS(1), .BLANK_TICKS(0)) dut2 (
        .clk(clk), .rst(rst2), .tick(tick2), .enable(en2),
        .frame_in(frame2), .frame_in_valid(valid2),
        .frame_in_ready(ready2), .vert(vert2), .row(row2),
        .cur_plane(plane2), .frame_done(done2), .busy(busy2)
    );

    function automatic exp_t ex(logic [2:0] v, logic [8:0] r, int p,
                                bit d, bit b, bit rd);
        exp_t e;
        e.vert  = v;
        e.row   = r;
        e.plane = 2'(p);
        e.done  = d;
        e.busy  = b;
        e.ready = rd;
        return e;
    endfunction

    function automatic exp_t eb(int p, bit d, bit rd);
        return ex(3'b000, 9'h000, p, d, 1'b1, rd);
    endfunction

    function automatic exp_t ed(int p, logic [26:0] f, bit d, bit rd);
        logic [26:0] t;
        logic [2:0]  v;
        t = f >> (p * 9);
        v = 3'b001 << p;
        return ex(v, t[8:0], p, d, 1'b1, rd);
    endfunction

    function automatic exp_t eidle(bit rd);
        return ex(3'b000, 9'h000, 0, 1'b0, 1'b0, rd);
    endfunction

    task automatic step(input string tag, input exp_t e);
        exp_t obs, want;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sel) obs = {vert2, row2, plane2, done2, busy2, ready2};
        else     obs = {vert, row, cur_plane, done, busy, ready};
        want = sb.pop_front();
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic run_frame(input logic [26:0] f, input bit d0,
                             input bit rdy, input int g);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < g; i++) begin
                tick = (i == 0);
                step($sformatf("blank_p%0d", p),
                     eb(p, d0 && p == 0 && i == 0, rdy));
            end
            for (int i = 0; i < 2 * g; i++) begin
                tick = (i % g == 0);
                step($sformatf("drive_p%0d", p), ed(p, f, 1'b0, rdy));
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; valid = 1'b1; tick = 1'b1;
        frame = 27'h5A5A5A5;
        rst2 = 1'b1; en2 = 1'b0; valid2 = 1'b0; tick2 = 1'b1;
        frame2 = F2;

        step("rst0", eidle(1'b1));
        enable = 1'b0; valid = 1'b0;
        step("rst1", eidle(1'b1));
        rst = 1'b0;

        frame = 27'h00001FF; valid = 1'b1;
        step("load_a", eidle(1'b0));
        valid = 1'b0;
        step("swap_idle", eidle(1'b1));
        enable = 1'b1;
        run_frame(27'h00001FF, 1'b0, 1'b1, 1);
        run_frame(27'h00001FF, 1'b1, 1'b1, 1);

        enable = 1'b0;
        step("stop", eidle(1'b1));
        frame = 27'h7FC0000; valid = 1'b1;
        step("load_b", eidle(1'b0));
        valid = 1'b0;
        step("swap_b", eidle(1'b1));

        enable = 1'b1; tick = 1'b1;
        step("db_blank0", eb(0, 1'b0, 1'b1));
        step("db_drive0", ed(0, 27'h7FC0000, 1'b0, 1'b1));
        frame = 27'h0000007; valid = 1'b1;
        step("db_offer", ed(0, 27'h7FC0000, 1'b0, 1'b0));
        valid = 1'b0;
        for (int p = 1; p < 3; p++) begin
            step("db_blank", eb(p, 1'b0, 1'b0));
            step("db_drive", ed(p, 27'h7FC0000, 1'b0, 1'b0));
            step("db_drive", ed(p, 27'h7FC0000, 1'b0, 1'b0));
        end
        run_frame(27'h0000007, 1'b1, 1'b1, 1);

        run_frame(27'h0000007, 1'b1, 1'b1, 3);

        tick = 1'b1;
        step("ab_blank0", eb(0, 1'b1, 1'b1));
        step("ab_drive0", ed(0, 27'h0000007, 1'b0, 1'b1));
        step("ab_drive0", ed(0, 27'h0000007, 1'b0, 1'b1));
        step("ab_blank1", eb(1, 1'b0, 1'b1));
        step("ab_drive1", ed(1, 27'h0000007, 1'b0, 1'b1));
        enable = 1'b0;
        step("ab_idle", eidle(1'b1));
        step("ab_idle2", eidle(1'b1));
        enable = 1'b1;
        run_frame(27'h0000007, 1'b0, 1'b1, 1);

        sel = 1'b1;
        rst2 = 1'b0; valid2 = 1'b1;
        step("nb_load", eidle(1'b0));
        valid2 = 1'b0;
        step("nb_swap", eidle(1'b1));
        en2 = 1'b1;
        step("nb_p0", ed(0, F2, 1'b0, 1'b1));
        step("nb_p1", ed(1, F2, 1'b0, 1'b1));
        step("nb_p2", ed(2, F2, 1'b0, 1'b1));
        for (int k = 0; k < 2; k++) begin
            step("nb_p0_done", ed(0, F2, 1'b1, 1'b1));
            step("nb_p1", ed(1, F2, 1'b0, 1'b1));
            step("nb_p2", ed(2, F2, 1'b0, 1'b1));
        end
        rst2 = 1'b1;
        step("nb_rst", eidle(1'b1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
